// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants, state codes and snapshot type for the display scanner
package display_pkg;

  localparam int          FIELD_COUNT     = 44;
  localparam int          NAME_W          = 40;
  localparam int          VALUE_W         = 32;
  localparam logic [3:0]  CHARS_PER_FIELD = 4'd13;
  localparam logic [3:0]  NAME_LEN        = 4'd5;
  localparam logic [3:0]  LAST_POS        = CHARS_PER_FIELD - 4'd1;

  localparam logic [7:0]  ASCII_ZERO      = 8'h30;
  localparam logic [7:0]  ASCII_A         = 8'h41;

  localparam logic [2:0]  ST_SETUP        = 3'd0;
  localparam logic [2:0]  ST_WAIT         = 3'd1;
  localparam logic [2:0]  ST_CAPTURE      = 3'd2;
  localparam logic [2:0]  ST_EMIT         = 3'd3;
  localparam logic [2:0]  ST_ADVANCE      = 3'd4;

  typedef struct packed {
    logic [NAME_W-1:0]  name;
    logic [VALUE_W-1:0] value;
  } snapshot_t;

endpackage

// File: rtl/display_scanner_if.sv
// rtl/display_scanner_if.sv - producer request/reply and character stream bundle
interface display_scanner_if;
  logic [5:0]  display_number;
  logic        display_valid;
  logic [39:0] display_name;
  logic [31:0] display_value;
  logic        char_valid;
  logic        char_ready;
  logic [5:0]  char_field;
  logic [3:0]  char_pos;
  logic [7:0]  char_data;
  logic        frame_done;

  modport master (
    output display_number,
    input  display_valid, display_name, display_value,
    output char_valid, char_field, char_pos, char_data, frame_done,
    input  char_ready
  );

  modport slave (
    input  display_number,
    output display_valid, display_name, display_value,
    input  char_valid, char_field, char_pos, char_data, frame_done,
    output char_ready
  );
endinterface

// File: rtl/hex_ascii.sv
// rtl/hex_ascii.sv - nibble to uppercase ASCII hex digit
module hex_ascii
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);
  assign ascii = (nibble < 4'd10) ? ASCII_ZERO + {4'h0, nibble}
                                  : ASCII_A + {4'h0, nibble - 4'd10};
endmodule

// File: rtl/display_scanner.sv
// rtl/display_scanner.sv - walks producer fields and streams name + hex value characters
module display_scanner
  import display_pkg::*;
#(
  parameter int NUM_FIELDS = FIELD_COUNT,
  parameter int SETTLE     = 2
) (
  input  logic              clk,
  input  logic              resetn,
  display_scanner_if.master bus
);
  localparam logic [5:0] LAST_FIELD  = 6'(NUM_FIELDS);
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  logic [2:0] state;
  logic [3:0] settle_cnt;
  logic [5:0] field;
  logic [3:0] pos;
  snapshot_t  snap;
  logic [2:0] nib_idx;
  logic [3:0] nib;
  logic [7:0] hex_char;
  logic [7:0] name_char;
  logic       emitting;
  logic       accept;

  assign emitting = (state == ST_EMIT);
  assign accept   = emitting && bus.char_ready;

  // pos 5..12 maps to nibble 7..0 of the value, MSB first
  assign nib_idx = 3'(LAST_POS - pos);
  assign nib     = 4'(snap.value >> {nib_idx, 2'b00});

  hex_ascii u_hex (
    .nibble (nib),
    .ascii  (hex_char)
  );

  always_comb begin
    name_char = 8'h00;
    case (pos)
      4'd0:    name_char = snap.name[39:32];
      4'd1:    name_char = snap.name[31:24];
      4'd2:    name_char = snap.name[23:16];
      4'd3:    name_char = snap.name[15:8];
      4'd4:    name_char = snap.name[7:0];
      default: name_char = 8'h00;
    endcase
  end

  assign bus.display_number = field;
  assign bus.char_valid     = emitting;
  assign bus.char_field     = emitting ? field : 6'd0;
  assign bus.char_pos       = emitting ? pos : 4'd0;
  assign bus.char_data      = !emitting ? 8'h00 : (pos < NAME_LEN) ? name_char : hex_char;
  assign bus.frame_done     = (state == ST_ADVANCE) && (field == LAST_FIELD);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_SETUP;
      settle_cnt <= 4'd0;
      field      <= 6'd1;
      pos        <= 4'd0;
      snap       <= '0;
    end else begin
      case (state)
        ST_SETUP: begin
          settle_cnt <= SETTLE_LOAD;
          state      <= ST_WAIT;
        end
        ST_WAIT: begin
          // WAIT plus CAPTURE together span SETTLE cycles
          if (settle_cnt <= 4'd1) state <= ST_CAPTURE;
          if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
        end
        ST_CAPTURE: begin
          snap.name  <= bus.display_name;
          snap.value <= bus.display_value;
          pos        <= 4'd0;
          state      <= bus.display_valid ? ST_EMIT : ST_ADVANCE;
        end
        ST_EMIT: begin
          if (accept) begin
            if (pos == LAST_POS) begin
              pos   <= 4'd0;
              state <= ST_ADVANCE;
            end else begin
              pos <= pos + 4'd1;
            end
          end
        end
        ST_ADVANCE: begin
          field <= (field == LAST_FIELD) ? 6'd1 : field + 6'd1;
          state <= ST_SETUP;
        end
        default: state <= ST_SETUP;
      endcase
    end
  end
endmodule
